// File: rtl/table_reader_pkg.sv
// table_reader_pkg: shared types for the table scanner
package table_reader_pkg;
    typedef enum logic [1:0] {IDLE, SCAN, FINISH} state_t;
endpackage

// File: rtl/table_reader_out_reg.sv
// table_reader_out_reg: one-entry valid/ready register carrying data, index and last
module table_reader_out_reg #(
    parameter int WIDTH = 16,
    parameter int AW    = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [AW-1:0]    in_index,
    input  logic             in_last,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    output logic [AW-1:0]    index,
    output logic             last
);
    // load replaces the held word; acceptance without a load empties the register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= '0;
            index <= '0;
            last  <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= in_data;
            index <= in_index;
            last  <= in_last;
        end else if (ready) begin
            valid <= 1'b0;
        end
    end
endmodule

// File: rtl/table_reader.sv
// table_reader: streams an external single-port table out in address order, host writes take priority
module table_reader
    import table_reader_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 64,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             done,
    input  logic             host_we,
    input  logic [AW-1:0]    host_addr,
    input  logic [WIDTH-1:0] host_din,
    output logic [AW-1:0]    ram_addr,
    output logic             ram_we,
    output logic [WIDTH-1:0] ram_din,
    input  logic [WIDTH-1:0] ram_dout,
    output logic [WIDTH-1:0] m_data,
    output logic [AW-1:0]    m_index,
    output logic             m_last,
    output logic             m_valid,
    input  logic             m_ready
);
    localparam logic [AW:0] LAST_RP = (AW+1)'(DEPTH-1);

    state_t      state, state_nx;
    logic [AW:0] rp;
    logic        capture;

    // an extra rp bit keeps "past the end" distinct from address 0
    assign ram_addr = host_we ? host_addr : rp[AW-1:0];
    assign ram_we   = host_we;
    assign ram_din  = host_din;
    assign capture  = (state == SCAN) && !host_we && (rp <= LAST_RP) && (!m_valid || m_ready);
    assign busy     = (state == SCAN);
    assign done     = (state == FINISH);

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // next state: start only honoured from IDLE, FINISH lasts one cycle
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = start ? SCAN : IDLE;
            SCAN:    state_nx = (m_valid && m_ready && m_last) ? FINISH : SCAN;
            FINISH:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // read pointer: cleared on an accepted start, advanced on every capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                         rp <= '0;
        else if (state == IDLE && start) rp <= '0;
        else if (capture)                rp <= rp + (AW+1)'(1);
    end

    table_reader_out_reg #(.WIDTH(WIDTH), .AW(AW)) out_reg (
        .clk      (clk),
        .rst      (rst),
        .load     (capture),
        .ready    (m_ready),
        .in_data  (ram_dout),
        .in_index (rp[AW-1:0]),
        .in_last  (rp == LAST_RP),
        .valid    (m_valid),
        .data     (m_data),
        .index    (m_index),
        .last     (m_last)
    );
endmodule

// File: tb/tb_table_reader.sv
// tb_table_reader: scoreboard bench for table_reader with a behavioural external table
module tb_table_reader;
    typedef struct packed {
        logic [5:0]  idx;
        logic [15:0] data;
        logic        last;
    } exp_t;

    logic        clk, rst, start, busy, done, host_we, ram_we, m_last, m_valid, m_ready;
    logic [5:0]  host_addr, ram_addr, m_index;
    logic [15:0] host_din, ram_din, ram_dout, m_data;
    logic [15:0] mem [64];
    logic [15:0] model [64];
    exp_t        q [$];
    int          compared, mismatched;

    table_reader dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .host_we(host_we), .host_addr(host_addr), .host_din(host_din),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_din(ram_din), .ram_dout(ram_dout),
        .m_data(m_data), .m_index(m_index), .m_last(m_last), .m_valid(m_valid), .m_ready(m_ready)
    );

    always #5 clk = ~clk;

    assign ram_dout = mem[ram_addr];

    // external table: asynchronous read, synchronous write
    always @(posedge clk) if (ram_we) mem[ram_addr] <= ram_din;

    task load_table(input int mode);
        for (int i = 0; i < 64; i++) begin
            model[i]  = (mode == 0) ? 16'(i * 3) : (16'hA5A5 ^ 16'(i * 257));
            host_we   = 1;
            host_addr = 6'(i);
            host_din  = model[i];
            @(negedge clk);
        end
        host_we = 0;
    endtask

    task push_all;
        for (int i = 0; i < 64; i++) q.push_back({6'(i), model[i], i == 63});
    endtask

    task pulse_start;
        start = 1;
        @(negedge clk);
        start = 0;
    endtask

    task test_reset;
        rst = 1;
        repeat (2) @(negedge clk);
        compared++;
        if ({busy, done, m_valid} !== 3'b000) begin
            mismatched++;
            $display("FAIL reset_ctrl: got busy/done/valid=%b want 000", {busy, done, m_valid});
        end
        compared++;
        if ({m_index, m_data, m_last} !== 23'd0) begin
            mismatched++;
            $display("FAIL reset_word: got idx=%0d data=%h last=%b want 0", m_index, m_data, m_last);
        end
        rst = 0;
        @(negedge clk);
    endtask

    task test_stream;
        exp_t e;
        int   got, gaps;
        load_table(0);
        push_all();
        m_ready = 1;
        pulse_start();
        compared++;
        if (busy !== 1'b1) begin
            mismatched++;
            $display("FAIL busy_after_start: got %b want 1", busy);
        end
        got  = 0;
        gaps = 0;
        for (int c = 0; c < 400 && q.size() > 0; c++) begin
            if (m_valid) begin
                e = q.pop_front();
                got++;
                compared++;
                if ({m_index, m_data, m_last} !== e) begin
                    mismatched++;
                    $display("FAIL stream_word: got idx=%0d data=%h last=%b want idx=%0d data=%h last=%b",
                             m_index, m_data, m_last, e.idx, e.data, e.last);
                end
            end else if (got > 0) gaps++;
            @(negedge clk);
        end
        compared++;
        if (q.size() != 0) begin
            mismatched++;
            $display("FAIL stream_timeout: got %0d words left want 0", q.size());
        end
        compared++;
        if (gaps != 0) begin
            mismatched++;
            $display("FAIL stream_gaps: got %0d idle cycles want 0", gaps);
        end
        compared++;
        if (done !== 1'b1) begin
            mismatched++;
            $display("FAIL stream_done: got %b want 1", done);
        end
        @(negedge clk);
        compared++;
        if ({done, busy} !== 2'b00) begin
            mismatched++;
            $display("FAIL stream_idle: got done/busy=%b want 00", {done, busy});
        end
    endtask

    task test_backpressure;
        exp_t        e;
        logic        stalled;
        logic [22:0] held;
        load_table(1);
        push_all();
        m_ready = 0;
        pulse_start();
        stalled = 0;
        held    = '0;
        for (int c = 0; c < 400 && q.size() > 0; c++) begin
            if (stalled) begin
                compared++;
                if (!m_valid || {m_index, m_data, m_last} !== held) begin
                    mismatched++;
                    $display("FAIL stall_hold: got valid=%b word=%h want valid=1 word=%h",
                             m_valid, {m_index, m_data, m_last}, held);
                end
            end
            m_ready = (c % 2 == 0);
            if (m_valid && m_ready) begin
                e = q.pop_front();
                compared++;
                if ({m_index, m_data, m_last} !== e) begin
                    mismatched++;
                    $display("FAIL stall_word: got idx=%0d data=%h last=%b want idx=%0d data=%h last=%b",
                             m_index, m_data, m_last, e.idx, e.data, e.last);
                end
            end
            stalled = m_valid && !m_ready;
            held    = {m_index, m_data, m_last};
            @(negedge clk);
        end
        compared++;
        if (q.size() != 0 || done !== 1'b1) begin
            mismatched++;
            $display("FAIL stall_end: got left=%0d done=%b want left=0 done=1", q.size(), done);
        end
        m_ready = 1;
        @(negedge clk);
    endtask

    task test_host_write;
        exp_t e;
        logic stall_chk;
        load_table(0);
        model[5] = 16'hBEEF;
        push_all();
        m_ready = 1;
        pulse_start();
        stall_chk = 0;
        for (int c = 0; c < 400 && q.size() > 0; c++) begin
            host_we = 0;
            if (stall_chk) begin
                compared++;
                if (m_valid !== 1'b0) begin
                    mismatched++;
                    $display("FAIL write_stall: got valid=%b want 0", m_valid);
                end
                stall_chk = 0;
            end
            if (m_valid) begin
                e = q.pop_front();
                compared++;
                if ({m_index, m_data, m_last} !== e) begin
                    mismatched++;
                    $display("FAIL write_word: got idx=%0d data=%h last=%b want idx=%0d data=%h last=%b",
                             m_index, m_data, m_last, e.idx, e.data, e.last);
                end
                if (m_index == 6'd4) begin
                    host_we   = 1;
                    host_addr = 6'd5;
                    host_din  = 16'hBEEF;
                    #1;
                    compared++;
                    if ({ram_we, ram_addr, ram_din} !== {1'b1, 6'd5, 16'hBEEF}) begin
                        mismatched++;
                        $display("FAIL write_port: got we=%b addr=%0d din=%h want we=1 addr=5 din=beef",
                                 ram_we, ram_addr, ram_din);
                    end
                    stall_chk = 1;
                end
            end
            @(negedge clk);
        end
        host_we = 0;
        compared++;
        if (q.size() != 0 || done !== 1'b1) begin
            mismatched++;
            $display("FAIL write_end: got left=%0d done=%b want left=0 done=1", q.size(), done);
        end
        @(negedge clk);
    endtask

    task test_restart_ignored;
        exp_t e;
        int   dones;
        push_all();
        m_ready = 1;
        pulse_start();
        dones = 0;
        for (int c = 0; c < 400 && q.size() > 0; c++) begin
            start = 0;
            if (done) dones++;
            if (m_valid) begin
                e = q.pop_front();
                compared++;
                if ({m_index, m_data, m_last} !== e) begin
                    mismatched++;
                    $display("FAIL restart_word: got idx=%0d data=%h last=%b want idx=%0d data=%h last=%b",
                             m_index, m_data, m_last, e.idx, e.data, e.last);
                end
                if (m_index == 6'd20) start = 1;
            end
            @(negedge clk);
        end
        start = 0;
        compared++;
        if (q.size() != 0 || done !== 1'b1) begin
            mismatched++;
            $display("FAIL restart_end: got left=%0d done=%b want left=0 done=1", q.size(), done);
        end
        if (done) dones++;
        pulse_start();
        compared++;
        if ({busy, done} !== 2'b00) begin
            mismatched++;
            $display("FAIL start_in_finish: got busy/done=%b want 00", {busy, done});
        end
        repeat (3) begin
            @(negedge clk);
            if (done) dones++;
        end
        compared++;
        if (dones != 1) begin
            mismatched++;
            $display("FAIL done_count: got %0d want 1", dones);
        end
    endtask

    task test_reset_mid;
        exp_t e;
        logic hit;
        int   bad;
        push_all();
        m_ready = 1;
        pulse_start();
        hit = 0;
        for (int c = 0; c < 400 && !hit; c++) begin
            if (m_valid && m_index == 6'd30) hit = 1;
            else begin
                if (m_valid) begin
                    e = q.pop_front();
                    compared++;
                    if ({m_index, m_data, m_last} !== e) begin
                        mismatched++;
                        $display("FAIL abort_word: got idx=%0d data=%h want idx=%0d data=%h",
                                 m_index, m_data, e.idx, e.data);
                    end
                end
                @(negedge clk);
            end
        end
        compared++;
        if (!hit) begin
            mismatched++;
            $display("FAIL abort_reach: got hit=0 want 1");
        end
        rst = 1;
        #1;
        compared++;
        if ({m_valid, busy, done, m_index} !== 9'd0) begin
            mismatched++;
            $display("FAIL abort_async: got valid=%b busy=%b done=%b idx=%0d want all 0",
                     m_valid, busy, done, m_index);
        end
        q.delete();
        @(negedge clk);
        rst = 0;
        bad = 0;
        repeat (4) begin
            @(negedge clk);
            if (done || busy || m_valid) bad++;
        end
        compared++;
        if (bad != 0) begin
            mismatched++;
            $display("FAIL abort_quiet: got %0d active cycles want 0", bad);
        end
        push_all();
        pulse_start();
        for (int c = 0; c < 400 && q.size() > 0; c++) begin
            if (m_valid) begin
                e = q.pop_front();
                compared++;
                if ({m_index, m_data, m_last} !== e) begin
                    mismatched++;
                    $display("FAIL rescan_word: got idx=%0d data=%h last=%b want idx=%0d data=%h last=%b",
                             m_index, m_data, m_last, e.idx, e.data, e.last);
                end
            end
            @(negedge clk);
        end
        compared++;
        if (q.size() != 0 || done !== 1'b1) begin
            mismatched++;
            $display("FAIL rescan_end: got left=%0d done=%b want left=0 done=1", q.size(), done);
        end
        @(negedge clk);
    endtask

    initial begin
        clk        = 0;
        rst        = 1;
        start      = 0;
        host_we    = 0;
        host_addr  = '0;
        host_din   = '0;
        m_ready    = 0;
        compared   = 0;
        mismatched = 0;
        test_reset();
        test_stream();
        test_backpressure();
        test_host_write();
        test_restart_ignored();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
